// File: rtl/instr_fetch_issue_if.sv
// Instruction register handshake between the fetch/issue unit (master, producer)
// and the execute core (slave, consumer).
interface instr_fetch_issue_if #(
    parameter int IW = 32
);
    logic [IW-1:0] ir_out;
    logic          ir_valid;
    logic          ir_ready;

    modport master (output ir_out, output ir_valid, input ir_ready);
    modport slave  (input ir_out, input ir_valid, output ir_ready);
endinterface

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue unit: walks a small program memory from address 0 and
// offers each word to the execute core over a valid/ready handshake.
module instr_fetch_issue #(
    parameter int         DEPTH  = 8,
    parameter int         IW     = 32,
    parameter logic [4:0] MAX_OP = 5'b01011
) (
    input  logic                     clk,
    input  logic                     sysreset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [IW-1:0]            load_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   prog_len,
    instr_fetch_issue_if.master      ir,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal,
    output logic [$clog2(DEPTH)-1:0] err_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] len;
    logic [LW-1:0] len_clamped;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] ir_word;
    logic          ir_vld;
    logic [IW-1:0] fetch_word;
    logic          fetch_bad;
    logic          issue_fire;
    logic          last_instr;

    assign fetch_word = mem[pc];
    assign fetch_bad  = fetch_word[IW-1 -: 5] > MAX_OP;
    assign issue_fire = ir_vld && ir.ir_ready;
    assign last_instr = ({1'b0, pc} == len - LW'(1));

    assign ir.ir_out   = ir_word;
    assign ir.ir_valid = ir_vld;

    // Requests longer than the memory run the whole memory once.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        len_clamped = prog_len;
        if (prog_len > LW'(DEPTH)) len_clamped = LW'(DEPTH);
    end

    // NOTE: program memory has no reset; contents survive sysreset so a run can be repeated.
    always_ff @(posedge clk) begin
        if (load_en && state == S_IDLE) mem[load_addr] <= load_data;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sysreset) begin
            state   <= S_IDLE;
            len     <= '0;
            pc      <= '0;
            ir_word <= '0;
            ir_vld  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            err_pc  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len <= len_clamped;
                        if (prog_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc    <= '0;
                            state <= S_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    ir_word <= fetch_word;
                    if (fetch_bad) begin
                        illegal <= 1'b1;
                        err_pc  <= pc;
                        state   <= S_ERR;
                        busy    <= 1'b0;
                    end else begin
                        ir_vld <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        ir_vld <= 1'b0;
                        if (last_instr) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios plus randomized
// programs and backpressure, checked against an array/queue reference model.
module tb_instr_fetch_issue;
    logic        clk = 1'b0;
    logic        sysreset;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [3:0]  prog_len;
    logic [2:0]  pc;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [2:0]  err_pc;

    instr_fetch_issue_if #(.IW(32)) ir_bus ();

    instr_fetch_issue dut (
        .clk       (clk),
        .sysreset  (sysreset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .prog_len  (prog_len),
        .ir        (ir_bus),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .err_pc    (err_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_legal_word();
        logic [4:0] op;
        op = 5'($urandom_range(11));
        return {op, 27'($urandom)};
    endfunction

    task automatic load_word(input logic [2:0] a, input logic [31:0] d, input bit accepted);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick;
        load_en = 1'b0;
        if (accepted) model_mem[a] = d;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({ir_bus.ir_out, ir_bus.ir_valid, pc, busy, done, illegal, err_pc} !== '0) begin
            n_fail++;
            $display("FAIL %s: ir_out=%h ir_valid=%b pc=%0d busy=%b done=%b illegal=%b err_pc=%0d, expected all zero",
                     tag, ir_bus.ir_out, ir_bus.ir_valid, pc, busy, done, illegal, err_pc);
        end
    endtask

    // Runs one program: the model expects the first min(plen,8) words of model_mem in
    // order, stable under stall, followed by a single done pulse.
    task automatic run_prog(input logic [3:0] plen, input int ready_pct, input int stall_idx,
                            input int stall_len, input bit do_load, input logic [2:0] la,
                            input logic [31:0] ld, input string tag);
        int          eff, n_hs, stall_cnt, done_cyc;
        bit          prev_stall, got_done;
        logic [31:0] prev_word;
        logic [2:0]  prev_pc;
        logic [31:0] exp_q [$];
        if (do_load) begin
            load_en = 1'b1; load_addr = la; load_data = ld;
            model_mem[la] = ld;
        end
        eff = (plen > 4'd8) ? 8 : int'(plen);
        for (int i = 0; i < eff; i++) exp_q.push_back(model_mem[i]);
        prog_len = plen; start = 1'b1;
        tick;
        start = 1'b0; load_en = 1'b0;
        n_hs = 0; stall_cnt = 0; prev_stall = 1'b0; got_done = 1'b0; done_cyc = -1;
        prev_word = '0; prev_pc = '0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            if (done === 1'b1) begin
                got_done = 1'b1; done_cyc = cyc;
            end else begin
                if (cyc == 0 && eff > 0) begin
                    n_checks++;
                    if (busy !== 1'b1 || ir_bus.ir_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s fetch_cycle: busy=%b ir_valid=%b, expected busy=1 ir_valid=0",
                                 tag, busy, ir_bus.ir_valid);
                    end
                end
                if (prev_stall) begin
                    n_checks++;
                    if (ir_bus.ir_valid !== 1'b1 || ir_bus.ir_out !== prev_word || pc !== prev_pc) begin
                        n_fail++;
                        $display("FAIL %s stall_hold: ir_valid=%b ir_out=%h pc=%0d, expected 1 %h %0d",
                                 tag, ir_bus.ir_valid, ir_bus.ir_out, pc, prev_word, prev_pc);
                    end
                end
                if (ir_bus.ir_valid === 1'b1 && n_hs == stall_idx && stall_cnt < stall_len) begin
                    ir_bus.ir_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    ir_bus.ir_ready = ($urandom_range(99) < ready_pct);
                end
                prev_stall = ir_bus.ir_valid && !ir_bus.ir_ready;
                prev_word  = ir_bus.ir_out;
                prev_pc    = pc;
                if (ir_bus.ir_valid === 1'b1 && ir_bus.ir_ready === 1'b1) begin
                    n_checks++;
                    if (n_hs >= eff) begin
                        n_fail++;
                        $display("FAIL %s extra_issue: got ir_out=%h at handshake %0d, expected only %0d issues",
                                 tag, ir_bus.ir_out, n_hs, eff);
                    end else if (ir_bus.ir_out !== exp_q[n_hs] || pc !== 3'(n_hs)) begin
                        n_fail++;
                        $display("FAIL %s word%0d: got ir_out=%h pc=%0d, expected ir_out=%h pc=%0d",
                                 tag, n_hs, ir_bus.ir_out, pc, exp_q[n_hs], n_hs);
                    end
                    n_hs++;
                end
                tick;
            end
        end
        ir_bus.ir_ready = 1'b0;
        n_checks++;
        if (!got_done || n_hs != eff) begin
            n_fail++;
            $display("FAIL %s completion: done_seen=%b handshakes=%0d, expected done_seen=1 handshakes=%0d",
                     tag, got_done, n_hs, eff);
        end
        if (got_done) begin
            n_checks++;
            if (busy !== 1'b0 || ir_bus.ir_valid !== 1'b0 || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_state: busy=%b ir_valid=%b illegal=%b, expected 0 0 0",
                         tag, busy, ir_bus.ir_valid, illegal);
            end
            if (eff > 0) begin
                n_checks++;
                if (pc !== 3'(eff - 1)) begin
                    n_fail++;
                    $display("FAIL %s final_pc: got %0d, expected %0d", tag, pc, eff - 1);
                end
            end
            if (ready_pct >= 100 && stall_len == 0) begin
                n_checks++;
                if (done_cyc != 2 * eff) begin
                    n_fail++;
                    $display("FAIL %s done_timing: done in cycle %0d after start, expected %0d",
                             tag, done_cyc, 2 * eff);
                end
            end
            tick;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, expected 0 0", tag, done, busy);
            end
        end
    endtask

    task automatic test_reset;
        sysreset = 1'b1;
        tick; tick;
        sysreset = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_load_and_run;
        load_word(3'd0, 32'h0840_0005, 1'b1);
        load_word(3'd1, 32'h1082_0003, 1'b1);
        load_word(3'd2, 32'h18C4_0001, 1'b1);
        run_prog(4'd3, 100, -1, 0, 1'b0, 3'd0, 32'h0, "load_run");
    endtask

    task automatic test_backpressure;
        run_prog(4'd3, 100, 1, 5, 1'b0, 3'd0, 32'h0, "backpressure");
        run_prog(4'd3, 40, -1, 0, 1'b0, 3'd0, 32'h0, "rand_backpressure");
    endtask

    task automatic test_boundaries;
        for (int a = 3; a < 8; a++) load_word(3'(a), rand_legal_word(), 1'b1);
        run_prog(4'd0, 100, -1, 0, 1'b0, 3'd0, 32'h0, "len0");
        run_prog(4'd8, 100, -1, 0, 1'b0, 3'd0, 32'h0, "len8");
        run_prog(4'd12, 100, -1, 0, 1'b0, 3'd0, 32'h0, "len12");
    endtask

    task automatic test_load_start;
        int  cyc;
        bit  seen_done;
        prog_len = 4'd2; start = 1'b1; ir_bus.ir_ready = 1'b0;
        tick;
        start = 1'b0;
        cyc = 0;
        while (ir_bus.ir_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        load_word(3'd0, 32'hDEAD_BEEF, 1'b0);
        ir_bus.ir_ready = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            else tick;
        end
        ir_bus.ir_ready = 1'b0;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL load_in_issue: done not seen within bound, expected done after 2 issues");
        end
        tick;
        run_prog(4'd1, 100, -1, 0, 1'b0, 3'd0, 32'h0, "mem_unchanged");
        run_prog(4'd3, 100, -1, 0, 1'b1, 3'd0, 32'h0840_0007, "load_with_start");
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        prog_len = 4'd3; start = 1'b1; ir_bus.ir_ready = 1'b0;
        tick;
        start = 1'b0;
        cyc = 0;
        while (ir_bus.ir_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        n_checks++;
        if (ir_bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_valid: ir_valid=%b, expected 1 before reset", ir_bus.ir_valid);
        end
        ir_bus.ir_ready = 1'b1;
        sysreset = 1'b1;
        tick;
        sysreset = 1'b0; ir_bus.ir_ready = 1'b0;
        check_reset_values("reset_mid_run");
        run_prog(4'd3, 100, -1, 0, 1'b0, 3'd0, 32'h0, "rerun_after_reset");
    endtask

    task automatic test_illegal;
        int n_hs;
        load_word(3'd1, 32'hF800_0000, 1'b1);
        prog_len = 4'd4; start = 1'b1;
        tick;
        start = 1'b0; ir_bus.ir_ready = 1'b1;
        n_hs = 0;
        for (int cyc = 0; cyc < 20 && illegal !== 1'b1; cyc++) begin
            if (ir_bus.ir_valid === 1'b1) begin
                n_checks++;
                if (n_hs != 0 || ir_bus.ir_out !== model_mem[0]) begin
                    n_fail++;
                    $display("FAIL illegal_issue: got ir_out=%h at handshake %0d, expected only %h",
                             ir_bus.ir_out, n_hs, model_mem[0]);
                end
                n_hs++;
            end
            tick;
        end
        ir_bus.ir_ready = 1'b0;
        n_checks++;
        if (illegal !== 1'b1 || err_pc !== 3'd1 || ir_bus.ir_valid !== 1'b0 || busy !== 1'b0 || n_hs != 1) begin
            n_fail++;
            $display("FAIL illegal_flag: illegal=%b err_pc=%0d ir_valid=%b busy=%b issues=%0d, expected 1 1 0 0 1",
                     illegal, err_pc, ir_bus.ir_valid, busy, n_hs);
        end
        load_en = 1'b1; load_addr = 3'd0; load_data = 32'h0000_0000;
        start = 1'b1; prog_len = 4'd2;
        tick;
        load_en = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (illegal !== 1'b1 || err_pc !== 3'd1 || ir_bus.ir_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL err_terminal: illegal=%b err_pc=%0d ir_valid=%b busy=%b done=%b, expected 1 1 0 0 0",
                         illegal, err_pc, ir_bus.ir_valid, busy, done);
            end
            tick;
        end
        sysreset = 1'b1;
        tick;
        sysreset = 1'b0;
        check_reset_values("reset_from_err");
        load_word(3'd1, 32'h1082_0003, 1'b1);
        run_prog(4'd3, 100, -1, 0, 1'b0, 3'd0, 32'h0, "after_err");
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 8; a++) load_word(3'(a), rand_legal_word(), 1'b1);
            run_prog(4'($urandom_range(15)), int'($urandom_range(100, 30)), -1, 0, 1'b0, 3'd0, 32'h0, "random");
        end
    endtask

    initial begin
        sysreset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0; ir_bus.ir_ready = 1'b0;
        test_reset;
        test_load_and_run;
        test_backpressure;
        test_boundaries;
        test_load_start;
        test_reset_mid_run;
        test_illegal;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
